mem_responder: RTL

- Memory-side responder for the processor's fetch/load/store bus. It answers instruction fetches (fetch state) and data reads/writes (LD, ST) issued by the processor's control FSM.
- Holds a word-addressed storage array and inserts a programmable number of wait states.
- Returns read data or a write acknowledge over a valid/ready response channel.
- Flags out-of-range addresses with an error response.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcode encodings, responder state encoding
// and default bus widths.
package cpu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 8;

    localparam logic [3:0] LD  = 4'h0;
    localparam logic [3:0] ADD = 4'h1;
    localparam logic [3:0] JMP = 4'h2;
    localparam logic [3:0] ST  = 4'h3;
    localparam logic [3:0] CMP = 4'h4;
    localparam logic [3:0] JEQ = 4'h5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_e;

    // Opcode field of a default-width instruction word.
    function automatic logic [3:0] opcode_of(input logic [DW_DEF-1:0] word);
        return word[DW_DEF-1:DW_DEF-4];
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the processor (master) and the memory
// responder (slave).
interface mem_responder_if
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed storage with programmable wait
// states, valid/ready response channel and out-of-range error flagging.
module mem_responder
    import cpu_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus,
    output logic           busy_o
);

    localparam int            CW       = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam int            IW       = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

    rsp_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          acc_s;
    logic          acc_we_s;
    logic [AW-1:0] acc_addr_s;
    logic [DW-1:0] acc_wdata_s;
    logic [IW-1:0] acc_idx_s;
    logic          in_range_s;
    logic          mem_wr_s;

    // Access operands: with zero wait states the access happens on the accept
    // edge, before the request registers are loaded, so use the live bus.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we_s    = bus.req_we;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
        end else begin
            acc_we_s    = we_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
        end
        acc_idx_s  = acc_addr_s[IW-1:0];
        in_range_s = ({1'b0, acc_addr_s} < DEPTH_W);
        mem_wr_s   = acc_s & acc_we_s & in_range_s & ~reset;
    end

    // Next-state, counter, request capture and response data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        acc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        acc_s   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    acc_s   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = {DW{1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
                rdata_d = {DW{1'b0}};
                err_d   = 1'b0;
            end
        endcase
        if (acc_s) begin
            err_d   = ~in_range_s;
            rdata_d = (in_range_s && !acc_we_s) ? mem_q[acc_idx_s] : {DW{1'b0}};
        end else begin
            err_d = err_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            we_q    <= 1'b0;
            addr_q  <= {AW{1'b0}};
            wdata_q <= {DW{1'b0}};
            rdata_q <= {DW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_wr_s) begin
            mem_q[acc_idx_s] <= acc_wdata_s;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy_o        = (state_q != IDLE);

endmodule
